sr_latch_checker: RTL and testbench
===================================

# sr_latch_checker

Synchronous protocol checker for the SR NOR latch. It sits on the response side of the latch's S/R stimulus and samples S, R and Q every clock. It tracks the state the latch must be in and flags Q mismatches, forbidden S=R=1 inputs and the race that follows their release. It also keeps a saturating error count for benches and on-chip self-test.

## Interface
- SETTLE, 2: sampling edges after a state change during which Q is not compared.
- CNT_W, 8: width of the error counter.

- clk  input  1  clock; all activity on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- s  input  1  latch set input, synchronous to clk.
- r  input  1  latch reset input, synchronous to clk.
- q  input  1  latch Q output, synchronous to clk.
- exp_q  output  1  expected Q (registered).
- exp_valid  output  1  exp_q is defined.
- mismatch  output  1  one-cycle pulse, start of a Q mismatch episode.
- forbidden  output  1  one-cycle pulse, entry into S=R=1.
- race  output  1  one-cycle pulse, release from S=R=1 to S=R=0.
- err_count  output  CNT_W  saturating count of mismatch, forbidden and race events.

## Operation
- FSM states are UNK (reset), SET, RST and FORB. The next state is decoded from the sampled {s,r}:
  - 10 goes to SET.
  - 01 goes to RST.
  - 11 goes to FORB.
  - 00 holds the current state, except that FORB goes to UNK.
- A sample that maps to the current state is not a transition (for example, 10 held in SET). It does not reload the settle counter.
- State outputs:
  - SET gives exp_q=1.
  - RST gives exp_q=0.
  - FORB gives exp_q=0, because both NOR outputs are low.
  - UNK gives exp_q=0 with exp_valid=0.
  - exp_valid is 1 in SET, RST and FORB.
- Settle counter:
  - Width is clog2(SETTLE+1), minimum 1.
  - Every transition loads it with SETTLE.
  - Otherwise it decrements while non-zero.
- Compare rule: a compare happens at an edge only when all of the following hold:
  - the current state is SET, RST or FORB;
  - the counter is 0 before the update;
  - the sampled {s,r} causes no transition.
- Mismatch episode:
  - The first failing compare (q != exp_q) while armed pulses mismatch and disarms.
  - A passing compare, a transition or a reset re-arms.
- forbidden pulses on every transition into FORB.
- race pulses on the FORB-to-UNK transition.
- err_count increments by 1 for each mismatch, forbidden or race pulse. At most one of these can occur per edge. The count saturates at 2^CNT_W-1.

## Timing
- Reset: rst sampled high at an edge overrides s, r and q. After that edge:
  - the state is UNK and the counter is 0;
  - exp_q, exp_valid, mismatch, forbidden, race and err_count are all 0;
  - the mismatch episode is armed.
- Reset mid-settle or mid-FORB discards all pending state. A later 00 sample produces no race.
- Latency: s/r sampled at edge n are reflected in exp_q and exp_valid after edge n. A pulse caused by edge n is high for exactly the cycle after edge n.
- Settle window: for a transition at edge n, q sampled at edges n+1 through n+SETTLE is ignored. The first compare is at edge n+SETTLE+1, provided no further transition occurs. With SETTLE=0 the first compare is at n+1.
- A transition and a compare never share an edge. The q sampled on a transition edge is ignored.
- No handshake is used; the block observes only and never back-pressures.

## Test plan
1. Reset, then hold s=1, r=0 with q rising 1 cycle later: exp_q=1 and exp_valid=1 from the first edge. mismatch never pulses and err_count stays 0.
2. Apply {s,r} = 10, 00, 01, 00, 11, 00 (10 cycles each) with an ideal q:
   - exp_q follows 1, 1, 0, 0, 0, then exp_valid=0;
   - forbidden pulses once and race pulses once;
   - err_count ends at 2.
3. Enter SET at edge n with q stuck at 0 and SETTLE=2:
   - a single mismatch pulse from edge n+3 and err_count=1, with no repeat while q stays 0;
   - then q=1 for one cycle followed by q=0 gives a second pulse and err_count=2.
4. Enter SET with q going high at edge n+2 and SETTLE=2: no mismatch and err_count stays 0.
5. With CNT_W=2, generate 5 forbidden/race events: err_count reads 1, 2, 3, 3, 3.
6. Enter FORB, then assert rst for one cycle during it, then apply 00:
   - all outputs are 0 after the reset edge;
   - the state is UNK and no race pulse occurs;
   - err_count holds its reset value.

Source files
------------

// File: rtl/sr_latch_checker.sv
// Protocol checker for an SR NOR latch. It tracks the state the latch should be in from
// the sampled S/R inputs and flags Q mismatches, forbidden S=R=1 inputs and release races.
module sr_latch_checker #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             forbidden,
    output logic             race,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

    typedef enum logic [1:0] {UNK, SET, RST, FORB} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             armed, armed_nx;
    logic             transition, compare, fail;
    logic             exp_q_nx, exp_valid_nx;
    logic             mismatch_nx, forbidden_nx, race_nx;
    logic [CNT_W-1:0] err_nx;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        armed_nx     = armed;
        err_nx       = err_count;

        unique case ({s, r})
            2'b10:   state_nx = SET;
            2'b01:   state_nx = RST;
            2'b11:   state_nx = FORB;
            default: if (state == FORB) state_nx = UNK;
        endcase

        // Re-entering the current state is a hold, not a transition.
        transition = (state_nx != state);
        compare    = (state != UNK) && (cnt == '0) && !transition;
        fail       = compare && (q != exp_q);

        if (transition)
            cnt_nx = SETTLE_LD;
        else if (cnt != '0)
            cnt_nx = cnt - 1'b1;

        mismatch_nx  = fail && armed;
        forbidden_nx = transition && (state_nx == FORB);
        race_nx      = (state == FORB) && (state_nx == UNK);

        if (transition || (compare && !fail))
            armed_nx = 1'b1;
        else if (mismatch_nx)
            armed_nx = 1'b0;

        exp_q_nx     = (state_nx == SET);
        exp_valid_nx = (state_nx != UNK);

        // At most one event per edge, so a single saturating increment suffices.
        if ((mismatch_nx || forbidden_nx || race_nx) && (err_count != '1))
            err_nx = err_count + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from
    // the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNK;
            cnt       <= '0;
            armed     <= 1'b1;
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
            mismatch  <= 1'b0;
            forbidden <= 1'b0;
            race      <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            armed     <= armed_nx;
            exp_q     <= exp_q_nx;
            exp_valid <= exp_valid_nx;
            mismatch  <= mismatch_nx;
            forbidden <= forbidden_nx;
            race      <= race_nx;
            err_count <= err_nx;
        end
    end

endmodule

// File: tb/tb_sr_latch_checker.sv
// Table-driven bench for sr_latch_checker: vectors carry hand-derived expectations that a
// scoreboard queue holds until the checker's registered outputs appear after the edge.
module tb_sr_latch_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s = 1'b0, r = 1'b0, q = 1'b0;
    logic       exp_q, exp_valid, mismatch, forbidden, race;
    logic [7:0] err_count;
    logic       sm_exp_q, sm_exp_valid, sm_mismatch, sm_forbidden, sm_race;
    logic [1:0] sm_err_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sr_latch_checker #(.SETTLE(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q),
        .exp_q(exp_q), .exp_valid(exp_valid), .mismatch(mismatch),
        .forbidden(forbidden), .race(race), .err_count(err_count)
    );

    // Same stimulus, narrow counter: shows saturation at 3.
    sr_latch_checker #(.SETTLE(2), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q),
        .exp_q(sm_exp_q), .exp_valid(sm_exp_valid), .mismatch(sm_mismatch),
        .forbidden(sm_forbidden), .race(sm_race), .err_count(sm_err_count)
    );

    typedef struct {
        logic rst, s, r, q;
        int   n;
        logic eq, ev, mm, fb, rc;
        int   ec;
    } vec_t;

    typedef struct {
        int   idx;
        logic eq, ev, mm, fb, rc;
        int   ec;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic rs, input logic si, input logic ri, input logic qi, input int n,
                       input logic eq, input logic ev, input logic mm, input logic fb,
                       input logic rc, input int ec);
        vec_t v;
        v.rst = rs; v.s = si; v.r = ri; v.q = qi; v.n = n;
        v.eq = eq; v.ev = ev; v.mm = mm; v.fb = fb; v.rc = rc; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pop one expectation per edge and compare both instances.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            int   ec_sat;
            e = sb.pop_front();
            ec_sat = (e.ec > 3) ? 3 : e.ec;
            check($sformatf("vec%0d_main", e.idx),
                  {3'b0, exp_q, exp_valid, mismatch, forbidden, race, err_count},
                  {3'b0, e.eq, e.ev, e.mm, e.fb, e.rc, 8'(e.ec)});
            check($sformatf("vec%0d_small", e.idx),
                  {9'b0, sm_exp_q, sm_exp_valid, sm_mismatch, sm_forbidden, sm_race, sm_err_count},
                  {9'b0, e.eq, e.ev, e.mm, e.fb, e.rc, 2'(ec_sat)});
        end
    end

    initial begin
        // Fields: rst s r q n | exp_q exp_valid mismatch forbidden race err_count
        // Pulse fields apply to the first cycle of a vector only.
        add(1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0);  // reset state
        // Set held, q rises one cycle after entry
        add(0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 6,  1, 1, 0, 0, 0, 0);
        // Full sequence with ideal q
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 10, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 10, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 10, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 10, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 10, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 10, 0, 0, 0, 0, 1, 2);
        // q stuck low after entering SET: one pulse at n+3, none while stuck
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 2,  1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1,  1, 1, 1, 0, 0, 1);
        add(0, 1, 0, 0, 4,  1, 1, 0, 0, 0, 1);
        add(0, 1, 0, 1, 1,  1, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1,  1, 1, 1, 0, 0, 2);
        add(0, 1, 0, 0, 3,  1, 1, 0, 0, 0, 2);
        // q low through edge n+2, high from n+3: inside the settle window
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 3,  1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 5,  1, 1, 0, 0, 0, 0);
        // Five forbidden/race events, then held FORB makes no repeat pulse
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1,  0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 2);
        add(0, 1, 1, 0, 1,  0, 1, 0, 1, 0, 3);
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 4);
        add(0, 1, 1, 0, 1,  0, 1, 0, 1, 0, 5);
        add(0, 1, 1, 0, 3,  0, 1, 0, 0, 0, 5);
        // Reset during FORB, then release: no race
        add(1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0);
        // Q high while RST is expected, then a transition
        add(0, 0, 1, 1, 3,  0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1,  0, 1, 1, 0, 0, 1);
        add(0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                exp_t e;
                @(negedge clk);
                rst = vecs[i].rst;
                s   = vecs[i].s;
                r   = vecs[i].r;
                q   = vecs[i].q;
                e.idx = i;
                e.eq  = vecs[i].eq;
                e.ev  = vecs[i].ev;
                e.mm  = (k == 0) ? vecs[i].mm : 1'b0;
                e.fb  = (k == 0) ? vecs[i].fb : 1'b0;
                e.rc  = (k == 0) ? vecs[i].rc : 1'b0;
                e.ec  = vecs[i].ec;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
